// File: rtl/execute_unit.sv
// rtl/execute_unit.sv - single-issue ALU with iterative multiplier and writeback forwarding
module execute_unit #(
  parameter int FWD_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  op,
  input  logic [3:0]  dst,
  input  logic [3:0]  srcA_sel,
  input  logic [3:0]  srcB_sel,
  input  logic [15:0] srcA,
  input  logic [15:0] srcB,
  output logic        wb_we,
  output logic [3:0]  wb_reg,
  output logic [15:0] wb_data,
  output logic        flag_z,
  output logic        flag_c,
  output logic        busy
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_MOV = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_CMP = 4'd9;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  state_t state, state_next;

  logic        accept;
  logic [15:0] opa, opb;

  logic [16:0] sum17, diff17;
  logic [31:0] shl32, shr32;
  logic [15:0] alu_res;
  logic        alu_c;
  logic        alu_wr;
  logic        alu_flags;

  logic [15:0] mul_mcand, mul_mplier, mul_acc, acc_next;
  logic [3:0]  mul_cnt, mul_dst;
  logic        mul_last;

  assign accept = in_valid && in_ready;

  // The writeback being presented this cycle is newer than the register file read.
  always_comb begin
    opa = srcA;
    opb = srcB;
    if (FWD_EN != 0 && wb_we && wb_reg == srcA_sel) opa = wb_data;
    if (FWD_EN != 0 && wb_we && wb_reg == srcB_sel) opb = wb_data;
  end

  // Wide shifts leave the last bit shifted out sitting just beyond the result field.
  assign sum17  = {1'b0, opa} + {1'b0, opb};
  assign diff17 = {1'b0, opa} - {1'b0, opb};
  assign shl32  = {16'h0000, opa} << opb[3:0];
  assign shr32  = {opa, 16'h0000} >> opb[3:0];

  always_comb begin
    alu_res   = 16'h0000;
    alu_c     = 1'b0;
    alu_wr    = 1'b1;
    alu_flags = 1'b1;
    case (op)
      OP_ADD: begin
        alu_res = sum17[15:0];
        alu_c   = sum17[16];
      end
      OP_SUB: begin
        alu_res = diff17[15:0];
        alu_c   = diff17[16];
      end
      OP_AND: alu_res = opa & opb;
      OP_OR:  alu_res = opa | opb;
      OP_XOR: alu_res = opa ^ opb;
      OP_SHL: begin
        alu_res = shl32[15:0];
        alu_c   = shl32[16];
      end
      OP_SHR: begin
        alu_res = shr32[31:16];
        alu_c   = shr32[15];
      end
      OP_MOV: alu_res = opb;
      OP_CMP: begin
        alu_res = diff17[15:0];
        alu_c   = diff17[16];
        alu_wr  = 1'b0;
      end
      default: begin
        alu_wr    = 1'b0;
        alu_flags = 1'b0;
      end
    endcase
  end

  assign acc_next = mul_acc + (mul_mplier[0] ? mul_mcand : 16'h0000);
  assign mul_last = (mul_cnt == 4'd15);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst && op == OP_MUL) state_next = S_MUL;
      end
      S_MUL: begin
        busy = 1'b1;
        if (mul_last) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_we      <= 1'b0;
      wb_reg     <= 4'd0;
      wb_data    <= 16'h0000;
      flag_z     <= 1'b0;
      flag_c     <= 1'b0;
      mul_mcand  <= 16'h0000;
      mul_mplier <= 16'h0000;
      mul_acc    <= 16'h0000;
      mul_cnt    <= 4'd0;
      mul_dst    <= 4'd0;
    end else begin
      wb_we <= 1'b0;
      if (accept) begin
        if (op == OP_MUL) begin
          mul_mcand  <= opa;
          mul_mplier <= opb;
          mul_acc    <= 16'h0000;
          mul_cnt    <= 4'd0;
          mul_dst    <= dst;
        end else begin
          if (alu_flags) begin
            flag_z <= (alu_res == 16'h0000);
            flag_c <= alu_c;
          end
          if (alu_wr) begin
            wb_we   <= 1'b1;
            wb_reg  <= dst;
            wb_data <= alu_res;
          end
        end
      end else if (state == S_MUL) begin
        // One multiplier bit per edge; only the low 16 product bits are kept.
        mul_acc    <= acc_next;
        mul_mcand  <= mul_mcand << 1;
        mul_mplier <= mul_mplier >> 1;
        mul_cnt    <= mul_cnt + 4'd1;
        if (mul_last) begin
          wb_we   <= 1'b1;
          wb_reg  <= mul_dst;
          wb_data <= acc_next;
          flag_z  <= (acc_next == 16'h0000);
          flag_c  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/execute_unit.md
EXECUTE_UNIT -- requirements
Module: execute_unit

Interface
REQ-001 Parameter: FWD_EN, default 1, writeback-to-operand forwarding enable (0 = operands used as received).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high. Ports below are listed as name, direction, width, meaning.
REQ-003 clk  in  1  clock; all state changes on its rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 in_valid  in  1  upstream presents an operation.
REQ-006 in_ready  out  1  block can accept; transfer occurs on an edge where in_valid and in_ready are both high.
REQ-007 op  in  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MOV, 8 MUL, 9 CMP, 10-15 NOP.
REQ-008 dst  in  4  destination register number.
REQ-009 srcA_sel, srcB_sel  in  4 each  register numbers the operands were read from.
REQ-010 srcA, srcB  in  16 each  operand values from the register file read ports.
REQ-011 wb_we  out  1  register file write enable.
REQ-012 wb_reg  out  4  register file write address.
REQ-013 wb_data  out  16  register file write data.
REQ-014 flag_z, flag_c  out  1 each  zero and carry flags.
REQ-015 busy  out  1  high while a MUL is iterating.

Function
REQ-016 The FSM SHALL have states IDLE and MUL; IDLE->MUL on accepting op 8; MUL->IDLE after 16 iteration edges.
REQ-017 in_ready SHALL be high in IDLE and low in MUL; busy SHALL equal (state==MUL).
REQ-018 An op other than MUL accepted at edge T SHALL have its result registered at T; wb_we high for exactly the following cycle; back-to-back accepts every cycle allowed.
REQ-019 MUL accepted at edge T0 SHALL run shift-add on edges T1..T16, register the low 16 bits of srcA*srcB at T16, and drive wb_we high for the one cycle after T16; in_ready is high again in that cycle.
REQ-020 All arithmetic is modulo 2^16; ADD C = carry out of bit 15; SUB/CMP compute srcA-srcB with C = borrow (srcA<srcB unsigned).
REQ-021 SHL/SHR SHALL shift srcA by srcB[3:0], zero fill; C = last bit shifted out; amount 0 gives srcA unchanged and C=0.
REQ-022 AND/OR/XOR/MOV(=srcB)/MUL SHALL set C=0; flag_z = (result==0) for every flag-updating op.
REQ-023 Flags SHALL update at the same edge the result is registered; NOP leaves flags, wb_data and wb_reg unchanged.
REQ-024 CMP and NOP SHALL NOT assert wb_we; CMP updates flags only.
REQ-025 With FWD_EN=1, if wb_we is high and wb_reg equals srcA_sel (resp. srcB_sel) at an accepting edge, wb_data SHALL replace srcA (resp. srcB); both may forward simultaneously.
REQ-026 wb_reg SHALL equal the accepted dst throughout the wb_we cycle; writes to register 0 are not special-cased.
REQ-027 in_valid while in_ready is low SHALL be ignored, with no side effects.

Reset
REQ-028 While rst is high at an edge: state IDLE, wb_we 0, wb_reg 0, wb_data 0, flag_z 0, flag_c 0, busy 0, MUL accumulator cleared.
REQ-029 in_ready SHALL be 0 during any cycle rst is high and 1 in the first cycle after rst deasserts.
REQ-030 Reset during MUL SHALL abort it with no writeback; in_valid during reset SHALL not be accepted.

Verification
REQ-031 ADD srcA=0xFFFF, srcB=0x0001, dst=3 -> next cycle wb_we=1, wb_reg=3, wb_data=0x0000, flag_z=1, flag_c=1.
REQ-032 MUL srcA=0x0123, srcB=0x0010, dst=5 -> busy and in_ready low for 16 cycles, then one wb_we cycle with wb_data=0x1230, flag_c=0.
REQ-033 ADD r1=r1+r1 (srcA=srcB=2) accepted at T, then ADD r2=r1+0 with stale srcA=2 at T+1 -> second writeback wb_data=0x0004 via forwarding (0x0002 with FWD_EN=0).
REQ-034 SHR srcA=0x8001 by 1 -> wb_data=0x4000, flag_c=1; SHL by 0 -> wb_data=srcA, flag_c=0.
REQ-035 CMP srcA=3, srcB=5 -> wb_we stays 0, flag_c=1, flag_z=0.
REQ-036 rst asserted 8 cycles into MUL -> no wb_we pulse, all outputs 0, in_ready=1 the cycle after rst drops.
